inst_enc: RTL and testbench
===========================

# inst_enc

RV32I instruction encoder: the inverse of the immediate-type decoder. It accepts an opcode, register/function fields and a full 32-bit immediate, classifies the immediate type from the opcode, and scatters the immediate bits into a 32-bit instruction word. A 2-entry output buffer with valid/ready on both sides lets it sit between a test-program generator or instruction-injection path and the fetch/IMEM write port of the pipeline.

## Interface
- No parameters.
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input request valid
- o_ready  out  1  input can be accepted (registered, = buffer not full)
- i_opcode  in  7  instruction opcode
- i_rd / i_rs1 / i_rs2  in  5 each  register fields
- i_funct3  in  3  funct3
- i_funct7  in  7  funct7 (R-type only)
- i_imm  in  32  immediate, byte offset, two's complement
- o_valid  out  1  o_inst valid
- i_ready  in  1  downstream accepts o_inst
- o_inst  out  32  encoded instruction
- o_imm_type  out  3  immediate type of o_inst
- o_err  out  1  immediate not representable (see Configuration)

## Operation
- Type map: 0110011→R; 0010011, 0000011, 1100111, 1110011→I; 0100011→S; 1100011→B; 1101111→J; 0110111, 0010111→U; any other→X.
- Packing: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; X {25'b0,op}.
- Fields unused by a type are ignored. Encoding is computed combinationally at the input; the buffer stores {inst, type, err}.
- Buffer: 2-entry FIFO, count 0..2. Push = i_valid & o_ready; pop = o_valid & i_ready. Order preserved.
- o_valid = (count != 0). Head entry on o_inst/o_imm_type/o_err is held stable while o_valid & !i_ready.

## Timing
- Reset values: o_valid=0, o_ready=1, o_inst=0, o_imm_type=0, o_err=0, count=0, pointers=0.
- Latency: an entry pushed at edge N is on the outputs with o_valid=1 after edge N when the buffer was empty.
- Throughput: 1 instruction per cycle when i_ready=1 continuously.
- count=2: o_ready=0; i_valid is ignored, and no push occurs even if a pop occurs in the same cycle. o_ready returns to 1 after the edge that pops.
- count=1 with push and pop in the same cycle: count stays 1, the new entry becomes head.
- count=0: a pop cannot occur; there is no bypass from input to output.
- Read/write pointers are 1 bit and wrap freely.
- Reset asserted mid-operation: all buffered entries are discarded, and outputs return to reset values on that edge.

## Configuration
- INST_ENC_RANGE_CHK_EN defined:
  - o_err=1 when i_imm is not representable. The rules are: I/S require a sign-extended 12-bit value; B requires sign-extended 13-bit with imm[0]=0; J requires sign-extended 21-bit with imm[0]=0; U requires imm[11:0]=0; type X is always an error; R never errors.
  - The word is still packed by truncation.
- Undefined: no check logic, o_err tied 0, truncation only.

## Structure
- Package inst_enc_pkg contains:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - imm-type constants shared with the decoder: IMM_R=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5, IMM_X=7.
- One sub-module, inst_enc_fifo2: a generic-width 2-entry FIFO that holds count, pointers and ready/valid. The encoder and range check are in the top module.

## Test plan
- ADDI: op=0010011, rd=1, rs1=0, f3=0, imm=5, i_ready=1 → o_inst=0x00500093, o_imm_type=1, o_err=0, one cycle after accept.
- SW and LUI back-to-back: SW with op=0100011, rs1=1, rs2=2, f3=2, imm=8, followed next cycle by LUI with op=0110111, rd=5, imm=0x12345000 → 0x0020A423 then 0x123452B7 on consecutive cycles.
- JAL: op=1101111, rd=1, imm=0x800 → 0x001000EF, o_imm_type=5.
- Range check (macro on): BEQ with imm=3 → o_err=1. I-type with imm=0x800 → o_err=1. The same vectors with the macro off → o_err=0.
- Backpressure: i_ready=0 and three requests presented → two are accepted and o_ready=0. Then i_ready=1 → the outputs appear in order, the third is accepted on the cycle after the first pop, and no entry is lost or duplicated.
- Reset while count=2 → next cycle o_valid=0, o_ready=1, o_inst=0, and the old entries never appear.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - opcode and immediate-type constants shared by the RV32I encoder and decoder
package inst_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5,
    IMM_X = 3'd7
  } imm_type_e;

  // Buffered entry: {inst[31:0], imm_type[2:0], err}
  localparam int ENTRY_W = 36;

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    case (op)
      OP_R:                                imm_type_of = IMM_R;
      OP_I, OP_LOAD, OP_JALR, OP_SYSTEM:   imm_type_of = IMM_I;
      OP_STORE:                            imm_type_of = IMM_S;
      OP_BRANCH:                           imm_type_of = IMM_B;
      OP_JAL:                              imm_type_of = IMM_J;
      OP_LUI, OP_AUIPC:                    imm_type_of = IMM_U;
      default:                             imm_type_of = IMM_X;
    endcase
  endfunction

endpackage

// File: rtl/inst_enc_fifo2.sv
// rtl/inst_enc_fifo2.sv - generic-width 2-entry valid/ready FIFO, no input-to-output bypass
module inst_enc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign wr_ready = (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = mem[rptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wr_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/inst_enc.sv
// rtl/inst_enc.sv - RV32I instruction encoder with 2-entry output buffer; INST_ENC_RANGE_CHK_EN enables immediate range errors
module inst_enc
  import inst_enc_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [2:0]  o_imm_type,
  output logic        o_err
);

  imm_type_e          imm_type;
  logic [31:0]        inst;
  logic               err;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;

  assign imm_type = imm_type_of(i_opcode);

  always_comb begin
    inst = {25'b0, i_opcode};
    case (imm_type)
      IMM_R: inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      IMM_I: inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      IMM_S: inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      IMM_B: inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], i_opcode};
      IMM_U: inst = {i_imm[31:12], i_rd, i_opcode};
      IMM_J: inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: inst = {25'b0, i_opcode};
    endcase
  end

`ifdef INST_ENC_RANGE_CHK_EN
  logic fits12;
  logic fits13;
  logic fits21;

  // A value fits N signed bits when every bit above N-1 repeats the sign bit.
  assign fits12 = (i_imm[31:11] == {21{i_imm[11]}});
  assign fits13 = (i_imm[31:12] == {20{i_imm[12]}});
  assign fits21 = (i_imm[31:20] == {12{i_imm[20]}});

  always_comb begin
    err = 1'b0;
    case (imm_type)
      IMM_I, IMM_S: err = ~fits12;
      IMM_B:        err = ~fits13 | i_imm[0];
      IMM_J:        err = ~fits21 | i_imm[0];
      IMM_U:        err = |i_imm[11:0];
      IMM_X:        err = 1'b1;
      default:      err = 1'b0;
    endcase
  end
`else
  assign err = 1'b0;
`endif

  assign wr_data = {inst, imm_type, err};

  inst_enc_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_valid (i_valid),
    .wr_ready (o_ready),
    .wr_data  (wr_data),
    .rd_valid (o_valid),
    .rd_ready (i_ready),
    .rd_data  (rd_data)
  );

  assign {o_inst, o_imm_type, o_err} = rd_data;

endmodule

// File: tb/tb_inst_enc.sv
// tb/tb_inst_enc.sv - self-checking bench for inst_enc with a queue-based reference model
module tb_inst_enc;
  import inst_enc_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_err;
  logic [6:0]  i_opcode, i_funct7;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3, o_imm_type;
  logic [31:0] i_imm, o_inst;

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  ty;
    logic        err;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;

`ifdef INST_ENC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  inst_enc dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst),
    .o_imm_type(o_imm_type), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference encoder built from field shifts and signed range arithmetic.
  function automatic ent_t ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
    ent_t e;
    int s;
    logic bad;
    logic [31:0] o, d, a, b, f, g;
    o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2); f = 32'(f3); g = 32'(f7);
    s = $signed(imm);
    case (op)
      7'b0110011: begin
        e.ty = 3'd0; bad = 1'b0;
        e.inst = o | (d << 7) | (f << 12) | (a << 15) | (b << 20) | (g << 25);
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        e.ty = 3'd1; bad = (s < -2048) || (s > 2047);
        e.inst = o | (d << 7) | (f << 12) | (a << 15) | ((imm & 32'hFFF) << 20);
      end
      7'b0100011: begin
        e.ty = 3'd2; bad = (s < -2048) || (s > 2047);
        e.inst = o | ((imm & 32'h1F) << 7) | (f << 12) | (a << 15) | (b << 20) | (((imm >> 5) & 32'h7F) << 25);
      end
      7'b1100011: begin
        e.ty = 3'd3; bad = (s < -4096) || (s > 4095) || imm[0];
        e.inst = o | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) | (f << 12) | (a << 15)
               | (b << 20) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      end
      7'b0110111, 7'b0010111: begin
        e.ty = 3'd4; bad = ((imm & 32'hFFF) != 0);
        e.inst = o | (d << 7) | (imm & 32'hFFFFF000);
      end
      7'b1101111: begin
        e.ty = 3'd5; bad = (s < -(1 << 20)) || (s >= (1 << 20)) || imm[0];
        e.inst = o | (d << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
               | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      end
      default: begin
        e.ty = 3'd7; bad = 1'b1; e.inst = o;
      end
    endcase
    e.err = CHK ? bad : 1'b0;
    return e;
  endfunction

  task automatic req(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    i_valid = v; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_funct3 = f3; i_imm = imm;
    i_funct7 = 7'($urandom);
  endtask

  // Advances one clock and applies the same transfer to the model queue.
  task automatic step();
    bit dpush, dpop;
    ent_t e;
    dpush = i_valid && (mq.size() < 2);
    dpop  = i_ready && (mq.size() > 0);
    e = ref_enc(i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm);
    @(posedge i_clk);
    if (i_rst) mq.delete();
    else begin
      if (dpop) void'(mq.pop_front());
      if (dpush) mq.push_back(e);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_ready = 1'b0;
    req(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    step(); step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", o_ready); end
    tests++; if ({o_inst, o_imm_type, o_err} !== 36'd0) begin fails++; $display("FAIL reset_outputs got %h/%0d/%b want 0", o_inst, o_imm_type, o_err); end
    i_rst = 1'b0;
  endtask

  task automatic test_addi();
    i_ready = 1'b1;
    req(1'b1, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL addi_valid got %b want 1", o_valid); end
    tests++; if (o_inst !== 32'h00500093) begin fails++; $display("FAIL addi_inst got %h want 00500093", o_inst); end
    tests++; if (o_imm_type !== 3'd1 || o_err !== 1'b0) begin fails++; $display("FAIL addi_type got %0d/%b want 1/0", o_imm_type, o_err); end
    step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL addi_drain got %b want 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    req(1'b1, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8); step();
    tests++; if (o_valid !== 1'b1 || o_inst !== 32'h0020A423) begin fails++; $display("FAIL sw_inst got %b/%h want 1/0020a423", o_valid, o_inst); end
    req(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000); step();
    i_valid = 1'b0;
    tests++; if (o_valid !== 1'b1 || o_inst !== 32'h123452B7) begin fails++; $display("FAIL lui_inst got %b/%h want 1/123452b7", o_valid, o_inst); end
    tests++; if (o_imm_type !== 3'd4) begin fails++; $display("FAIL lui_type got %0d want 4", o_imm_type); end
    step();
  endtask

  task automatic test_jal();
    i_ready = 1'b1;
    req(1'b1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800); step();
    i_valid = 1'b0;
    tests++; if (o_inst !== 32'h001000EF || o_imm_type !== 3'd5) begin fails++; $display("FAIL jal got %h/%0d want 001000ef/5", o_inst, o_imm_type); end
    step();
  endtask

  task automatic test_range();
    i_ready = 1'b1;
    req(1'b1, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3); step();
    tests++; if (o_inst !== 32'h00000163 || o_err !== CHK) begin fails++; $display("FAIL beq_odd got %h/%b want 00000163/%b", o_inst, o_err, CHK); end
    req(1'b1, OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 32'h800); step();
    tests++; if (o_inst !== 32'h80000013 || o_err !== CHK) begin fails++; $display("FAIL addi_800 got %h/%b want 80000013/%b", o_inst, o_err, CHK); end
    req(1'b1, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0); step();
    tests++; if (o_inst !== 32'h0000007F || o_imm_type !== 3'd7 || o_err !== CHK) begin fails++; $display("FAIL type_x got %h/%0d/%b want 0000007f/7/%b", o_inst, o_imm_type, o_err, CHK); end
    i_valid = 1'b0; step();
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      req(1'b1, OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 32'(k)); step();
    end
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", o_ready); end
    tests++; if (o_inst !== 32'h00100013) begin fails++; $display("FAIL bp_hold got %h want 00100013", o_inst); end
    i_ready = 1'b1; step();
    tests++; if (o_inst !== 32'h00200013 || o_ready !== 1'b1) begin fails++; $display("FAIL bp_second got %h/%b want 00200013/1", o_inst, o_ready); end
    step();
    i_valid = 1'b0;
    tests++; if (o_inst !== 32'h00300013 || o_valid !== 1'b1) begin fails++; $display("FAIL bp_third got %h/%b want 00300013/1", o_inst, o_valid); end
    step();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", o_valid); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    req(1'b1, OP_I, 5'd3, 5'd4, 5'd0, 3'd0, 32'd9); step();
    req(1'b1, OP_I, 5'd3, 5'd4, 5'd0, 3'd0, 32'd10); step();
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_full got %b want 0", o_ready); end
    i_valid = 1'b0; i_rst = 1'b1; step();
    tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_inst !== 32'd0 || o_imm_type !== 3'd0) begin
      fails++; $display("FAIL rst_mid got v%b r%b %h/%0d want v0 r1 0/0", o_valid, o_ready, o_inst, o_imm_type);
    end
    i_rst = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_stale cycle %0d got %b want 0", k, o_valid); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    logic [31:0] imm;
    int bnd [10];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, 7'h00};
    bnd = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 1048574, 1048576, -1048576};
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'(bnd[$urandom_range(0, 9)]);
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      req($urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)],
          5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
      i_ready = ($urandom_range(0, 3) != 0);
      step();
      tests++; if (o_ready !== (mq.size() < 2)) begin fails++; $display("FAIL rand_ready n=%0d got %b want %b", n, o_ready, mq.size() < 2); end
      tests++; if (o_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rand_valid n=%0d got %b want %b", n, o_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        tests++;
        if ({o_inst, o_imm_type, o_err} !== mq[0]) begin
          fails++; $display("FAIL rand_head n=%0d got %h/%0d/%b want %h/%0d/%b", n, o_inst, o_imm_type, o_err, mq[0].inst, mq[0].ty, mq[0].err);
        end
      end
    end
    i_valid = 1'b0; i_ready = 1'b1; step(); step();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
